// File: rtl/push_intr_pkg.sv
// Shared register map, bit positions and FSM encoding for the push-button
// interrupt controller.
package push_intr_pkg;

  localparam logic [1:0] ADDR_CTRL   = 2'd0;
  localparam logic [1:0] ADDR_STATUS = 2'd1;
  localparam logic [1:0] ADDR_COUNT  = 2'd2;
  localparam logic [1:0] ADDR_SNAP   = 2'd3;

  localparam int CTRL_ENABLE_BIT   = 0;
  localparam int CTRL_CLR_CNT_BIT  = 1;
  localparam int STAT_PENDING_BIT  = 0;
  localparam int STAT_OVERFLOW_BIT = 1;
  localparam int STAT_STATE_LSB    = 2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PEND = 2'd1,
    ST_HOLD = 2'd2
  } intr_state_e;

endpackage

// File: rtl/push_edge_det.sv
// Rising-edge pulse on the debounced event, disarmed for the first cycle after
// reset so a level already high at reset release is not taken as an edge.
module push_edge_det (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_sig,
  output logic o_rise
);

  logic r_prev;
  logic r_armed;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_prev  <= 1'b0;
      r_armed <= 1'b0;
    end else begin
      r_prev  <= i_sig;
      r_armed <= 1'b1;
    end
  end

  assign o_rise = i_sig & ~r_prev & r_armed;

endmodule

// File: rtl/push_intr_ctrl.sv
// Push-button interrupt controller: latches debounced events as a pending IRQ
// with overflow, event count, LED snapshot and a post-acknowledge hold-off.
//
// state | meaning
// IDLE  | nothing pending, irq low
// PEND  | event latched, irq follows ENABLE
// HOLD  | acknowledged; hold-off timer running, new events deferred
module push_intr_ctrl
  import push_intr_pkg::*;
#(
  parameter int HOLDOFF = 16,
  parameter int CNT_W   = 8
) (
  input  logic        S_AXI_ACLK,
  input  logic        S_AXI_ARESETN,
  input  logic        intr_src,
  input  logic [3:0]  led_on,
  input  logic        reg_wr,
  input  logic        reg_rd,
  input  logic [1:0]  reg_addr,
  input  logic [31:0] reg_wdata,
  output logic [31:0] reg_rdata,
  output logic        reg_rvalid,
  output logic        irq
);

  localparam int TMR_W = (HOLDOFF > 1) ? $clog2(HOLDOFF) : 1;
  localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(HOLDOFF - 1);

  intr_state_e      r_state;
  logic             r_pending;
  logic             r_overflow;
  logic             r_deferred;
  logic [TMR_W-1:0] r_timer;
  logic             r_irq;
  logic             r_enable;
  logic [CNT_W-1:0] r_count;
  logic [3:0]       r_snap;
  logic [31:0]      r_rdata;
  logic             r_rvalid;

  logic        w_event;
  logic        w_wr_ctrl;
  logic        w_wr_stat;
  logic        w_clr_cnt;
  logic        w_w1c_pend;
  logic        w_w1c_ovf;
  logic        w_ack;
  logic        w_ovf_set;
  logic [31:0] w_rd_data;
  logic        w_unused_wdata;

  push_edge_det u_edge_det (
    .i_clk   (S_AXI_ACLK),
    .i_rst_n (S_AXI_ARESETN),
    .i_sig   (intr_src),
    .o_rise  (w_event)
  );

  assign w_wr_ctrl      = reg_wr & (reg_addr == ADDR_CTRL);
  assign w_wr_stat      = reg_wr & (reg_addr == ADDR_STATUS);
  assign w_clr_cnt      = w_wr_ctrl & reg_wdata[CTRL_CLR_CNT_BIT];
  assign w_w1c_pend     = w_wr_stat & reg_wdata[STAT_PENDING_BIT];
  assign w_w1c_ovf      = w_wr_stat & reg_wdata[STAT_OVERFLOW_BIT];
  assign w_unused_wdata = ^reg_wdata[31:2];

  // A same-cycle event beats the acknowledge: the interrupt stays pending.
  assign w_ack     = (r_state == ST_PEND) & w_w1c_pend & ~w_event;
  assign w_ovf_set = (r_state == ST_PEND) & w_event & ~w_w1c_pend;

  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      r_state    <= ST_IDLE;
      r_pending  <= 1'b0;
      r_deferred <= 1'b0;
      r_timer    <= '0;
      r_irq      <= 1'b0;
    end else begin
      r_irq <= r_pending & r_enable & ~w_ack;
      case (r_state)
        ST_IDLE: begin
          if (w_event) begin
            r_state   <= ST_PEND;
            r_pending <= 1'b1;
          end
        end
        ST_PEND: begin
          if (w_ack) begin
            r_state    <= ST_HOLD;
            r_pending  <= 1'b0;
            r_timer    <= TMR_LOAD;
            r_deferred <= 1'b0;
          end
        end
        ST_HOLD: begin
          if (r_timer == '0) begin
            r_deferred <= 1'b0;
            if (r_deferred | w_event) begin
              r_state   <= ST_PEND;
              r_pending <= 1'b1;
            end else begin
              r_state <= ST_IDLE;
            end
          end else begin
            r_timer    <= r_timer - 1'b1;
            r_deferred <= r_deferred | w_event;
          end
        end
        default: begin
          r_state   <= ST_IDLE;
          r_pending <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      r_overflow <= 1'b0;
      r_enable   <= 1'b0;
      r_count    <= '0;
      r_snap     <= 4'h0;
    end else begin
      if (w_ovf_set) begin
        r_overflow <= 1'b1;
      end else if (w_w1c_ovf) begin
        r_overflow <= 1'b0;
      end
      if (w_wr_ctrl) begin
        r_enable <= reg_wdata[CTRL_ENABLE_BIT];
      end
      // Clear then count, so a clear coinciding with an event leaves 1.
      if (w_clr_cnt) begin
        r_count <= w_event ? CNT_W'(1) : '0;
      end else if (w_event) begin
        r_count <= r_count + 1'b1;
      end
      if (w_event) begin
        r_snap <= led_on;
      end
    end
  end

  always_comb begin
    w_rd_data = '0;
    case (reg_addr)
      ADDR_CTRL: w_rd_data[CTRL_ENABLE_BIT] = r_enable;
      ADDR_STATUS: begin
        w_rd_data[STAT_PENDING_BIT]        = r_pending;
        w_rd_data[STAT_OVERFLOW_BIT]       = r_overflow;
        w_rd_data[STAT_STATE_LSB +: 2]     = r_state;
      end
      ADDR_COUNT: w_rd_data[CNT_W-1:0] = r_count;
      default: w_rd_data[3:0] = r_snap;
    endcase
  end

  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      r_rdata  <= '0;
      r_rvalid <= 1'b0;
    end else begin
      r_rvalid <= reg_rd;
      if (reg_rd) begin
        r_rdata <= w_rd_data;
      end
    end
  end

  assign reg_rdata  = r_rdata;
  assign reg_rvalid = r_rvalid;
  assign irq        = r_irq;

endmodule

// File: tb/tb_push_intr_ctrl.sv
// Scoreboard bench for push_intr_ctrl: directed scenarios plus random traffic
// checked against a behavioural model of the register and interrupt rules.
module tb_push_intr_ctrl;

  localparam int HOLDOFF = 16;
  localparam int CNT_W   = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        src = 1'b0;
  logic [3:0]  led = 4'h0;
  logic        wr = 1'b0;
  logic        rd = 1'b0;
  logic [1:0]  addr = 2'd0;
  logic [31:0] wdata = '0;
  logic [31:0] rdata;
  logic        rvalid;
  logic        irq;

  always #5 clk = ~clk;

  push_intr_ctrl #(.HOLDOFF(HOLDOFF), .CNT_W(CNT_W)) dut (
    .S_AXI_ACLK    (clk),
    .S_AXI_ARESETN (rst_n),
    .intr_src      (src),
    .led_on        (led),
    .reg_wr        (wr),
    .reg_rd        (rd),
    .reg_addr      (addr),
    .reg_wdata     (wdata),
    .reg_rdata     (rdata),
    .reg_rvalid    (rvalid),
    .irq           (irq)
  );

  // st: 0 idle, 1 pending, 2 held off until cycle hold_end
  typedef struct packed {
    bit          en;
    int unsigned count;
    bit [3:0]    snap;
    bit          pend;
    bit          ov;
    int          st;
    int          hold_end;
    bit          defer;
    bit          irq;
    bit          rvalid;
    bit          prev;
    bit          armed;
  } mdl_t;

  mdl_t        cur;
  mdl_t        nxt;
  int          cyc = 0;
  int          vectors = 0;
  int          miscompares = 0;
  logic [31:0] exp_q[$];
  logic [31:0] last_exp = '0;
  bit          mon_on = 1'b0;

  function automatic mdl_t mdl_reset();
    mdl_t m;
    m = '0;
    return m;
  endfunction

  function automatic logic [31:0] mdl_read(mdl_t m, logic [1:0] a);
    case (a)
      2'd0:    return {31'd0, m.en};
      2'd1:    return {28'd0, m.st[1:0], m.ov, m.pend};
      2'd2:    return m.count;
      default: return {28'd0, m.snap};
    endcase
  endfunction

  function automatic mdl_t mdl_step(mdl_t m, int c, logic s, logic [3:0] l,
                                    logic w, logic [1:0] a, logic [31:0] d, logic r);
    mdl_t n;
    bit   ev, clr, w1p, w1o, ovset;
    n     = m;
    ev    = m.armed && s && !m.prev;
    n.prev  = s;
    n.armed = 1'b1;
    clr   = w && a == 2'd0 && d[1];
    w1p   = w && a == 2'd1 && d[0];
    w1o   = w && a == 2'd1 && d[1];
    ovset = 1'b0;
    if (w && a == 2'd0) n.en = d[0];
    if (clr) n.count = ev ? 1 : 0;
    else if (ev) n.count = (m.count + 1) % (1 << CNT_W);
    if (ev) n.snap = l;
    case (m.st)
      0: if (ev) begin n.st = 1; n.pend = 1'b1; end
      1: begin
        ovset = ev && !w1p;
        if (w1p && !ev) begin
          n.st = 2; n.pend = 1'b0; n.defer = 1'b0; n.hold_end = c + HOLDOFF;
        end
      end
      default: begin
        if (c == m.hold_end) begin
          n.defer = 1'b0;
          if (m.defer || ev) begin n.st = 1; n.pend = 1'b1; end
          else n.st = 0;
        end else begin
          n.defer = m.defer || ev;
        end
      end
    endcase
    if (ovset) n.ov = 1'b1;
    else if (w1o) n.ov = 1'b0;
    n.irq    = m.pend && m.en && n.st != 2;
    n.rvalid = r;
    return n;
  endfunction

  task automatic drive(input logic s, input logic [3:0] l, input logic w,
                       input logic r, input logic [1:0] a, input logic [31:0] d);
    @(posedge clk);
    #1;
    cur   = nxt;
    src   = s;
    led   = l;
    wr    = w;
    rd    = r;
    addr  = a;
    wdata = d;
    if (r) exp_q.push_back(mdl_read(cur, a));
    nxt = mdl_step(cur, cyc, s, l, w, a, d, r);
    cyc++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(src, led, 1'b0, 1'b0, 2'd0, 32'd0);
  endtask

  task automatic rd_reg(input logic [1:0] a);
    drive(src, led, 1'b0, 1'b1, a, 32'd0);
  endtask

  task automatic wr_reg(input logic [1:0] a, input logic [31:0] d);
    drive(src, led, 1'b1, 1'b0, a, d);
  endtask

  task automatic pulse(input logic [3:0] l);
    drive(1'b0, l, 1'b0, 1'b0, 2'd0, 32'd0);
    drive(1'b1, l, 1'b0, 1'b0, 2'd0, 32'd0);
  endtask

  task automatic do_reset(input logic s);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    src   = s;
    wr    = 1'b0;
    rd    = 1'b0;
    addr  = 2'd0;
    wdata = '0;
    cur   = mdl_reset();
    nxt   = cur;
    exp_q.delete();
    last_exp = '0;
    repeat (2) @(posedge clk);
    #2;
    vectors++;
    if (rdata !== 32'd0) begin
      miscompares++;
      $display("FAIL reset_rdata got=%h exp=%h", rdata, 32'd0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    nxt = mdl_step(cur, cyc, s, led, 1'b0, 2'd0, 32'd0, 1'b0);
    cyc++;
  endtask

  always @(negedge clk) begin
    logic [31:0] e;
    if (mon_on) begin
      vectors++;
      if (irq !== cur.irq) begin
        miscompares++;
        $display("FAIL irq cyc=%0d got=%b exp=%b", cyc, irq, cur.irq);
      end
      vectors++;
      if (rvalid !== cur.rvalid) begin
        miscompares++;
        $display("FAIL rvalid cyc=%0d got=%b exp=%b", cyc, rvalid, cur.rvalid);
      end
      if (rvalid === 1'b1) begin
        vectors++;
        if (exp_q.size() == 0) begin
          miscompares++;
          $display("FAIL rdata_unexpected cyc=%0d got=%h exp=none", cyc, rdata);
        end else begin
          e = exp_q.pop_front();
          last_exp = e;
          if (rdata !== e) begin
            miscompares++;
            $display("FAIL rdata cyc=%0d got=%h exp=%h", cyc, rdata, e);
          end
        end
      end else if (rst_n === 1'b1) begin
        vectors++;
        if (rdata !== last_exp) begin
          miscompares++;
          $display("FAIL rdata_hold cyc=%0d got=%h exp=%h", cyc, rdata, last_exp);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired cyc=%0d got=running exp=finished", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    logic        s;
    logic        w;
    logic        r;
    logic [1:0]  a;
    logic [31:0] d;
    cur    = mdl_reset();
    nxt    = cur;
    src    = 1'b1;
    mon_on = 1'b1;

    // Level high across reset release is not an event
    do_reset(1'b1);
    idle(10);
    rd_reg(2'd2);
    rd_reg(2'd1);

    // First event with ENABLE set
    wr_reg(2'd0, 32'd1);
    drive(1'b0, 4'h5, 1'b0, 1'b0, 2'd0, 32'd0);
    drive(1'b1, 4'h5, 1'b0, 1'b0, 2'd0, 32'd0);
    idle(3);
    rd_reg(2'd1);
    rd_reg(2'd2);
    rd_reg(2'd3);

    // Overflow, then acknowledge both bits
    pulse(4'h6);
    idle(2);
    rd_reg(2'd1);
    rd_reg(2'd2);
    rd_reg(2'd3);
    wr_reg(2'd1, 32'd3);
    idle(1);
    rd_reg(2'd1);
    idle(20);

    // Event deferred during hold-off
    pulse(4'h7);
    idle(2);
    wr_reg(2'd1, 32'd1);
    idle(4);
    pulse(4'h8);
    for (int i = 0; i < 14; i++) rd_reg(2'd1);
    idle(4);
    rd_reg(2'd2);

    // Acknowledge colliding with an event
    drive(1'b0, 4'h9, 1'b0, 1'b0, 2'd0, 32'd0);
    drive(1'b1, 4'h9, 1'b1, 1'b0, 2'd1, 32'd1);
    idle(2);
    rd_reg(2'd1);

    // ENABLE toggling while pending
    wr_reg(2'd0, 32'd0);
    idle(3);
    wr_reg(2'd0, 32'd1);
    idle(3);

    // Counter wrap and clear-with-event
    wr_reg(2'd0, 32'd3);
    for (int i = 0; i < 256; i++) pulse(4'(i));
    rd_reg(2'd2);
    drive(1'b0, 4'hA, 1'b0, 1'b0, 2'd0, 32'd0);
    drive(1'b1, 4'hA, 1'b1, 1'b1, 2'd0, 32'd3);
    rd_reg(2'd2);
    rd_reg(2'd3);

    // Reset in the middle of a hold-off with a deferred event
    wr_reg(2'd1, 32'd3);
    idle(3);
    pulse(4'hB);
    idle(1);
    do_reset(1'b0);
    idle(20);
    rd_reg(2'd1);
    rd_reg(2'd2);

    // Random traffic
    wr_reg(2'd0, 32'd1);
    s = src;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 3) == 0) s = ~s;
      r = ($urandom_range(0, 2) == 0);
      w = ($urandom_range(0, 9) == 0);
      a = 2'($urandom_range(0, 3));
      d = $urandom;
      if (w && a == 2'd0 && $urandom_range(0, 1) == 1) d[0] = 1'b1;
      drive(s, 4'($urandom_range(0, 15)), w, r, a, d);
    end
    idle(5);

    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL read_queue_drain got=%0d exp=0", exp_q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
